booth_iter_counter: RTL

- Parametrised iteration counter for the Booth multiplier controller.
- Loads an iteration count, decrements by a configurable step, and reports last-iteration, zero and a one-cycle done pulse.
- Supports a run-time load value, so radix-2 and radix-4 Booth variants and different operand widths share one block.
- Sits between the Booth control FSM (drives start/decr/abort) and the shift/add datapath.

---
 rtl/booth_iter_counter_if.sv | 26 ++
 rtl/booth_iter_counter.sv | 84 ++++++++
 2 files changed

// File: rtl/booth_iter_counter_if.sv
// Handshake bundle between the Booth control FSM (master) and the iteration counter (slave).
interface booth_iter_counter_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             use_ext;
    logic [WIDTH-1:0] ext_val;
    logic             decr;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             last;
    logic             zero;
    logic             done;
    logic             underflow;

    modport master (
        output start, use_ext, ext_val, decr, abort,
        input  count, busy, last, zero, done, underflow
    );

    modport slave (
        input  start, use_ext, ext_val, decr, abort,
        output count, busy, last, zero, done, underflow
    );
endinterface

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth multiplier controller: loads a count, steps it down
// on decr, and flags last iteration, zero, completion and saturating underflow.
module booth_iter_counter #(
    parameter int WIDTH      = 5,
    parameter int ITERATIONS = 16,
    parameter int STEP       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_iter_counter_if.slave   bus
);
    if (ITERATIONS < 1 || ITERATIONS > (2**WIDTH) - 1) begin : g_bad_iterations
        $error("booth_iter_counter: ITERATIONS out of range for WIDTH");
    end
    if (STEP < 1 || STEP > ITERATIONS) begin : g_bad_step
        $error("booth_iter_counter: STEP must be within 1..ITERATIONS");
    end
    if ($bits(bus.count) != WIDTH) begin : g_bad_if_width
        $error("booth_iter_counter: interface WIDTH does not match module WIDTH");
    end

    localparam logic [WIDTH-1:0] ITER_W = WIDTH'(ITERATIONS);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_underflow;

    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_diff;

    assign w_load = bus.use_ext ? bus.ext_val : ITER_W;
    assign w_diff = r_count - STEP_W;

    // State advances on the falling edge so the datapath, which works on the
    // rising edge, always sees a settled count.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else if (bus.abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else if (bus.start) begin
            r_count     <= w_load;
            r_underflow <= 1'b0;
            r_state     <= (w_load == '0) ? S_DONE : S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.decr) begin
                        if (r_count >= STEP_W) begin
                            r_count <= w_diff;
                            if (w_diff == '0) begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            // Saturate rather than wrap when the step overshoots.
                            r_count     <= '0;
                            r_underflow <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.count     = r_count;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.zero      = (r_count == '0);
    assign bus.last      = (r_state == S_RUN) && (r_count <= STEP_W) && (r_count != '0);
    assign bus.underflow = r_underflow;
endmodule
